buffer2axis: RTL and testbench



---
 rtl/buffer2axis.sv | 105 ++++++++++
 tb/tb_buffer2axis.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/buffer2axis.sv
// Streams a captured binary Game-of-Life grid as AXI4-Stream colour pixels,
// one cell per beat in row-major order, with TLAST on the final cell.
module buffer2axis #(
    parameter int DWIDTH = 32,
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DWIDTH-1:0]         alive_color,
    input  logic [DWIDTH-1:0]         dead_color,
    input  logic [WIDTH*HEIGHT-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DWIDTH-1:0]         M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic                      M_AXIS_TLAST,
    output logic [31:0]               frame_count
);

    localparam int          NPIX     = WIDTH * HEIGHT;
    localparam int          IW       = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [31:0] LAST_IDX = 32'(NPIX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Handshakes: a frame moves on in_valid & in_ready; a beat moves on
    // M_AXIS_TVALID & M_AXIS_TREADY. Neither input feeds an output directly.
    state_t              state_q, state_d;
    logic [NPIX-1:0]     grid_q, grid_d;
    logic [DWIDTH-1:0]   alive_q, alive_d;
    logic [DWIDTH-1:0]   dead_q, dead_d;
    logic [31:0]         index_q, index_d;
    logic [31:0]         frame_count_q, frame_count_d;

    logic                is_last;
    logic                beat_xfer;

    assign is_last   = (index_q == LAST_IDX);
    assign beat_xfer = (state_q == SEND) && M_AXIS_TREADY;

    always_comb begin
        state_d       = state_q;
        grid_d        = grid_q;
        alive_d       = alive_q;
        dead_d        = dead_q;
        index_d       = index_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    grid_d  = in_data;
                    alive_d = alive_color;
                    dead_d  = dead_color;
                    index_d = 32'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat_xfer) begin
                    if (is_last) begin
                        index_d       = 32'd0;
                        state_d       = IDLE;
                        frame_count_d = frame_count_q + 32'd1;
                    end else begin
                        index_d = index_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grid_q        <= '0;
            alive_q       <= '0;
            dead_q        <= '0;
            index_q       <= 32'd0;
            frame_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            grid_q        <= grid_d;
            alive_q       <= alive_d;
            dead_q        <= dead_d;
            index_q       <= index_d;
            frame_count_q <= frame_count_d;
        end
    end

    // in_ready is gated by rst so the block never advertises readiness while held in reset.
    assign in_ready      = (state_q == IDLE) && !rst;
    assign M_AXIS_TVALID = (state_q == SEND);
    assign M_AXIS_TLAST  = (state_q == SEND) && is_last;
    assign M_AXIS_TDATA  = (state_q == SEND) ?
                           (grid_q[index_q[IW-1:0]] ? alive_q : dead_q) : '0;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_buffer2axis.sv
// Directed bench for buffer2axis: table of frames with ready patterns, plus
// hand sequences for reset behaviour and a mid-frame reset.
module tb_buffer2axis;

    localparam int DW   = 32;
    localparam int NPIX = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     alive_color = '0;
    logic [DW-1:0]     dead_color  = '0;
    logic [NPIX-1:0]   in_data     = '0;
    logic              in_valid    = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     tdata;
    logic              tvalid;
    logic              tready      = 1'b1;
    logic              tlast;
    logic [31:0]       frame_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_fc = 32'd0;
    logic [DW-1:0] exp_q[$];

    buffer2axis #(.DWIDTH(DW), .WIDTH(4), .HEIGHT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .alive_color  (alive_color),
        .dead_color   (dead_color),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .M_AXIS_TDATA (tdata),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TREADY(tready),
        .M_AXIS_TLAST (tlast),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NPIX-1:0] data;
        logic [DW-1:0]   alive;
        logic [DW-1:0]   dead;
        logic [31:0]     ready_pat;
        int              exp_cycles;
        logic            mutate;
        logic            hold_valid;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        exp_fc = 32'd0;
    endtask

    task automatic send_frame(input vec_t v);
        int iter;
        int n;
        logic stalled_prev;
        logic [DW-1:0] prev_d;
        logic prev_l;
        logic [DW-1:0] e;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_tvalid", 32'(tvalid), 32'd0);
        in_data = v.data;
        alive_color = v.alive;
        dead_color = v.dead;
        in_valid = 1'b1;
        for (int k = 0; k < NPIX; k++) exp_q.push_back(v.data[k] ? v.alive : v.dead);
        step();
        if (v.mutate) begin
            in_data = 16'hFFFF;
            alive_color = 32'h12345678;
        end else if (!v.hold_valid) begin
            in_valid = 1'b0;
        end
        iter = 0;
        n = 0;
        stalled_prev = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        while (n < NPIX && iter < 100) begin
            tready = v.ready_pat[iter % 32];
            if (tvalid !== 1'b1) begin
                check("tvalid_in_frame", 32'(tvalid), 32'd1);
                break;
            end
            if (stalled_prev) begin
                check("stall_tdata_hold", tdata, prev_d);
                check("stall_tlast_hold", 32'(tlast), 32'(prev_l));
            end
            prev_d = tdata;
            prev_l = tlast;
            stalled_prev = !tready;
            if (tready) begin
                e = exp_q.pop_front();
                check("pixel", tdata, e);
                check("tlast", 32'(tlast), (n == NPIX - 1) ? 32'd1 : 32'd0);
                n++;
            end
            step();
            iter++;
        end
        tready = 1'b1;
        check("frame_cycles", 32'(iter), 32'(v.exp_cycles));
        exp_q.delete();
        exp_fc = exp_fc + 32'd1;
        check("frame_count", frame_count, exp_fc);
        check("end_in_ready", 32'(in_ready), 32'd1);
        check("end_tvalid", 32'(tvalid), 32'd0);
        check("end_tlast", 32'(tlast), 32'd0);
        check("end_tdata", tdata, 32'd0);
        if (!v.hold_valid) in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'hA5A5, 32'h00FFFFFF, 32'h00000000, 32'hFFFFFFFF, 16, 1'b0, 1'b0};
        vecs[1] = '{16'hA5A5, 32'h00FFFFFF, 32'h00000000, 32'h99999999, 32, 1'b0, 1'b0};
        vecs[2] = '{16'h3C81, 32'hCAFE0001, 32'h0BAD0002, 32'hFFFFFFFF, 16, 1'b1, 1'b0};
        vecs[3] = '{16'h8001, 32'hFFFFFFFF, 32'h11111111, 32'hFFFFFFFF, 16, 1'b0, 1'b1};
        vecs[4] = '{16'h7E00, 32'h0000FF00, 32'h00FF0000, 32'hFFFFFFFF, 16, 1'b0, 1'b1};
        vecs[5] = '{16'h00FF, 32'h55AA55AA, 32'hAA55AA55, 32'hFFFFFFFF, 16, 1'b0, 1'b0};

        // Reset and idle outputs.
        do_reset();
        step();
        check("idle_tvalid0", 32'(tvalid), 32'd0);
        check("idle_tlast0", 32'(tlast), 32'd0);
        check("idle_tdata0", tdata, 32'd0);
        check("idle_in_ready0", 32'(in_ready), 32'd1);
        check("idle_fc0", frame_count, 32'd0);

        // Checkerboard, backpressure, input isolation.
        for (int i = 0; i < 3; i++) send_frame(vecs[i]);
        step();
        check("no_reaccept_tvalid", 32'(tvalid), 32'd0);

        // Reset after beat 7 of a frame.
        in_data = 16'hA5A5;
        alive_color = 32'h00FFFFFF;
        dead_color = 32'h0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("mid_pixel", tdata, ((16'hA5A5 >> k) & 16'h1) != 0 ? 32'h00FFFFFF : 32'h0);
            check("mid_tlast", 32'(tlast), 32'd0);
            step();
        end
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", 32'(tvalid), 32'd0);
        check("mid_rst_tlast", 32'(tlast), 32'd0);
        check("mid_rst_tdata", tdata, 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        exp_fc = 32'd0;
        check("post_rst_fc", frame_count, 32'd0);
        check("post_rst_tvalid", 32'(tvalid), 32'd0);
        begin
            vec_t one;
            one = '{16'h0001, 32'h00FFFFFF, 32'h00000000, 32'hFFFFFFFF, 16, 1'b0, 1'b0};
            send_frame(one);
        end

        // Three back-to-back frames with in_valid held high.
        do_reset();
        for (int i = 3; i < 6; i++) send_frame(vecs[i]);
        check("b2b_fc3", frame_count, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
